transmitter: RTL and testbench

Source end of the Sel/Data link. It buffers bytes from an upstream valid/ready producer in a small FIFO. Each rising edge of the receiver-driven `sel` advances the next buffered byte onto `data`. It sits opposite the receiver on the `monInterface` (master side: drives Data, observes Sel). Underruns are counted for debug.

---
 rtl/mon_pkg.sv | 8 +
 rtl/mon_fifo.sv | 64 ++++++
 rtl/transmitter.sv | 75 +++++++
 tb/tb_transmitter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mon_pkg.sv
// Shared types for the Sel/Data monitor link, used by both transmitter and receiver sides.
package mon_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t MON_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/mon_fifo.sv
// Synchronous FIFO with occupancy counter; power-of-two DEPTH so pointers wrap naturally.
module mon_fifo
    import mon_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [7:0]               i_wdata,
    input  logic                     i_pop,
    output logic [7:0]               o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [AW:0] FULL_LEVEL = LW'(DEPTH);

    byte_t         r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == FULL_LEVEL);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    // Storage needs no reset: cleared pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_level = r_level;

endmodule

// File: rtl/transmitter.sv
// Source end of the Sel/Data link: buffers upstream bytes and advances one onto data
// per rising edge of the receiver's sel, counting requests that find the buffer empty.
module transmitter
    import mon_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter byte_t       IDLE_BYTE = MON_IDLE_BYTE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sel,
    output logic [7:0]               data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun,
    output logic [7:0]               underrun_cnt
);

    logic       r_sel_q;
    logic [7:0] r_data;
    logic       r_underrun;
    logic [7:0] r_underrun_cnt;

    logic       w_req;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;

    assign w_req    = sel && !r_sel_q;
    // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot early.
    assign in_ready = !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = w_req && !w_empty;

    mon_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel_q        <= 1'b0;
            r_data         <= IDLE_BYTE;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 8'd0;
        end else begin
            r_sel_q    <= sel;
            r_underrun <= w_req && w_empty;
            if (w_pop) begin
                r_data <= w_head;
            end
            if (w_req && w_empty && (r_underrun_cnt != 8'hFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 8'd1;
            end
        end
    end

    assign data         = r_data;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for transmitter: stimulus queues hand-computed responses per request,
// a monitor compares them one cycle after each sel rising edge it observes.
module tb_transmitter;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       sel;
    logic [7:0] data;
    logic [2:0] level;
    logic       underrun;
    logic [7:0] underrun_cnt;

    typedef struct packed {
        logic       u;
        logic [7:0] d;
        logic [7:0] c;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;

    transmitter #(
        .DEPTH     (4),
        .IDLE_BYTE (8'h00)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sel          (sel),
        .data         (data),
        .level        (level),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    // Receiver pattern: sel high 2 cycles, low 2 cycles.
    task automatic request(input logic u, input logic [7:0] d, input logic [7:0] c);
        sb_q.push_back('{u: u, d: d, c: c});
        sel = 1'b1;
        step();
        step();
        sel = 1'b0;
        step();
        step();
    endtask

    task automatic chk_level(input string name, input logic [31:0] exp_v);
        @(negedge clk);
        cmp(name, {29'd0, level}, exp_v);
        step();
    endtask

    // Monitor: independent sel edge detect; checks response, and quiet/stable outputs otherwise.
    initial begin : monitor
        logic       tb_sel_q;
        logic       pending;
        logic [7:0] last_data;
        logic [7:0] last_cnt;
        exp_t       e;
        tb_sel_q  = 1'b0;
        pending   = 1'b0;
        last_data = 8'h00;
        last_cnt  = 8'd0;
        @(negedge rst);
        forever begin
            @(negedge clk);
            if (!rst) begin
                tb_sel_q  = 1'b0;
                pending   = 1'b0;
                last_data = 8'h00;
                last_cnt  = 8'd0;
            end else begin
                if (pending) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_underflow: got request with no entry expected one queued");
                    end else begin
                        e = sb_q.pop_front();
                        cmp("req_data", {24'd0, data}, {24'd0, e.d});
                        cmp("req_underrun", {31'd0, underrun}, {31'd0, e.u});
                        cmp("req_underrun_cnt", {24'd0, underrun_cnt}, {24'd0, e.c});
                        last_data = e.d;
                        last_cnt  = e.c;
                    end
                end else begin
                    cmp("idle_underrun", {31'd0, underrun}, 32'd0);
                    cmp("idle_data_stable", {24'd0, data}, {24'd0, last_data});
                    cmp("idle_cnt_stable", {24'd0, underrun_cnt}, {24'd0, last_cnt});
                end
                pending  = sel && !tb_sel_q;
                tb_sel_q = sel;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        sel      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset asserted mid-clock takes effect without an edge.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        cmp("rst_data", {24'd0, data}, 32'h00);
        cmp("rst_in_ready", {31'd0, in_ready}, 32'd1);
        cmp("rst_level", {29'd0, level}, 32'd0);
        cmp("rst_underrun_cnt", {24'd0, underrun_cnt}, 32'd0);
        cmp("rst_underrun", {31'd0, underrun}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        // Basic send.
        push_byte(8'hA5);
        push_byte(8'h3C);
        chk_level("basic_level2", 32'd2);
        request(1'b0, 8'hA5, 8'd0);
        chk_level("basic_level1", 32'd1);
        request(1'b0, 8'h3C, 8'd0);
        chk_level("basic_level0", 32'd0);

        // Underrun, then underrun with a same-cycle push that must not bypass.
        request(1'b1, 8'h3C, 8'd1);
        sb_q.push_back('{u: 1'b1, d: 8'h3C, c: 8'd2});
        sel      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        in_valid = 1'b0;
        step();
        sel = 1'b0;
        step();
        step();
        chk_level("nobypass_level1", 32'd1);
        request(1'b0, 8'h77, 8'd2);

        // Full / backpressure.
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        @(negedge clk);
        cmp("full_in_ready", {31'd0, in_ready}, 32'd0);
        cmp("full_level4", {29'd0, level}, 32'd4);
        step();
        in_valid = 1'b1;
        in_data  = 8'h55;
        step();
        step();
        chk_level("full_hold_level4", 32'd4);
        sb_q.push_back('{u: 1'b0, d: 8'h11, c: 8'd2});
        sel = 1'b1;
        step();
        @(negedge clk);
        cmp("full_pop_level3", {29'd0, level}, 32'd3);
        cmp("full_pop_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        sel      = 1'b0;
        step();
        step();
        chk_level("full_refill_level4", 32'd4);
        request(1'b0, 8'h22, 8'd2);
        request(1'b0, 8'h33, 8'd2);
        request(1'b0, 8'h44, 8'd2);
        request(1'b0, 8'h55, 8'd2);
        chk_level("full_drain_level0", 32'd0);

        // Level-held sel pops once; then receiver pattern drains in order.
        push_byte(8'hAA);
        push_byte(8'hBB);
        sb_q.push_back('{u: 1'b0, d: 8'hAA, c: 8'd2});
        sel = 1'b1;
        repeat (10) step();
        chk_level("held_sel_level1", 32'd1);
        sel = 1'b0;
        step();
        step();
        push_byte(8'hC1);
        push_byte(8'hC2);
        request(1'b0, 8'hBB, 8'd2);
        request(1'b0, 8'hC1, 8'd2);
        request(1'b0, 8'hC2, 8'd2);
        chk_level("pattern_level0", 32'd0);

        // Saturation: 260 further empty requests.
        for (int k = 3; k < 263; k++) begin
            request(1'b1, 8'hC2, (k > 255) ? 8'hFF : 8'(k));
        end
        @(negedge clk);
        cmp("sat_cnt", {24'd0, underrun_cnt}, 32'd255);
        step();

        // Reset mid-operation with bytes buffered.
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        chk_level("prereset_level3", 32'd3);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        cmp("midrst_level", {29'd0, level}, 32'd0);
        cmp("midrst_cnt", {24'd0, underrun_cnt}, 32'd0);
        cmp("midrst_data", {24'd0, data}, 32'h00);
        cmp("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        rst = 1'b1;
        step();
        push_byte(8'h5A);
        request(1'b0, 8'h5A, 8'd0);
        chk_level("postrst_level0", 32'd0);

        step();
        step();
        cmp("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
